genius_gravador: RTL and testbench

Sequence recorder for the Genius game: captures a player-entered sequence of button presses into an internal 16x7 RAM so it can later be replayed and checked in place of the fixed sequence ROMs. It is the writer end of the sequence memory interface that the game datapath reads through an address/data port. It sits beside the game datapath and is driven by the same debounced `botoes` bus.

---
 rtl/genius_pkg.sv | 23 ++
 rtl/contador_m.sv | 25 ++
 rtl/ram_16x7.sv | 34 +++
 rtl/genius_gravador.sv | 153 +++++++++++++++
 tb/tb_genius_gravador.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared constants, state encoding and press check for the Genius sequence recorder
package genius_pkg;

    localparam int DEF_DEPTH    = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_N_BOTOES = 7;
    localparam int DEF_TIMEOUT  = 5000;

    typedef enum logic [2:0] {
        INICIAL  = 3'd0,
        ESPERA   = 3'd1,
        REGISTRA = 3'd2,
        SOLTA    = 3'd3,
        FIM      = 3'd4,
        ERRO     = 3'd5
    } estado_t;

    // A legal press has exactly one button down.
    function automatic logic um_quente(input logic [DEF_N_BOTOES-1:0] v);
        return (v != '0) && ((v & (v - DEF_N_BOTOES'(1))) == '0);
    endfunction

endpackage

// File: rtl/contador_m.sv
// rtl/contador_m.sv - modulo-M up counter with asynchronous clear and terminal-count flag
module contador_m #(
    parameter int M = 5000,
    parameter int N = $clog2(M)
) (
    input  logic clock,
    input  logic zera_as,
    input  logic conta,
    output logic fim
);

    logic [N-1:0] q;

    // Count while enabled; zera_as forces zero immediately and holds it there.
    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            q <= '0;
        end else if (conta) begin
            q <= (q == N'(M - 1)) ? '0 : q + N'(1);
        end
    end

    assign fim = (q == N'(M - 1));

endmodule

// File: rtl/ram_16x7.sv
// rtl/ram_16x7.sv - sequence RAM with synchronous write and registered read
module ram_16x7 #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int W      = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_endereco,
    input  logic [W-1:0]      wr_dado,
    input  logic [ADDR_W-1:0] rd_endereco,
    output logic [W-1:0]      rd_dado
);

    logic [W-1:0] mem [0:DEPTH-1];

    // Storage is never reset so a recording survives a reset pulse.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_endereco] <= wr_dado;
        end
    end

    // Registered read; a same-address write in the same cycle returns the old word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_dado <= '0;
        end else begin
            rd_dado <= mem[rd_endereco];
        end
    end

endmodule

// File: rtl/genius_gravador.sv
// rtl/genius_gravador.sv - records a player-entered button sequence into RAM for later replay
module genius_gravador
    import genius_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_BOTOES = DEF_N_BOTOES,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                finalizar,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic [ADDR_W-1:0]   rd_endereco,
    output logic [N_BOTOES-1:0] rd_dado,
    output logic                gravando,
    output logic                pronto,
    output logic                erro,
    output logic                timeout,
    output logic [ADDR_W-1:0]   tamanho,
    output logic [2:0]          db_estado
);

    localparam int CNT_W = ADDR_W + 1;

    estado_t             estado;
    estado_t             estado_prox;
    logic [N_BOTOES-1:0] botoes_r;
    logic [N_BOTOES-1:0] jogada;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_mais_um;
    logic [ADDR_W-1:0]   wr_addr;
    logic                zera_idle;
    logic                conta_idle;
    logic                idle_fim;
    logic                valida;
    logic                invalida;
    logic                tem_jogadas;
    logic                por_timeout;
    logic                escreve;

    assign valida        = um_quente(botoes_r);
    assign invalida      = (botoes_r != '0) && !valida;
    assign tem_jogadas   = (count != '0);
    assign count_mais_um = count + CNT_W'(1);
    assign conta_idle    = (estado == ESPERA);
    assign escreve       = (estado == REGISTRA);

    // Next-state decision; finalizar outranks presses, presses outrank the idle timeout.
    always_comb begin
        estado_prox = estado;
        por_timeout = 1'b0;
        case (estado)
            INICIAL: begin
                if (iniciar) estado_prox = ESPERA;
            end
            ESPERA: begin
                if (finalizar && tem_jogadas) begin
                    estado_prox = FIM;
                end else if (invalida) begin
                    estado_prox = ERRO;
                end else if (valida) begin
                    estado_prox = REGISTRA;
                end else if (idle_fim) begin
                    por_timeout = 1'b1;
                    estado_prox = tem_jogadas ? FIM : ERRO;
                end
            end
            REGISTRA: begin
                estado_prox = (count_mais_um == CNT_W'(DEPTH)) ? FIM : SOLTA;
            end
            SOLTA: begin
                if (finalizar && tem_jogadas) begin
                    estado_prox = FIM;
                end else if (botoes_r == '0) begin
                    estado_prox = ESPERA;
                end
            end
            FIM, ERRO: begin
                if (iniciar) estado_prox = ESPERA;
            end
            default: estado_prox = INICIAL;
        endcase
    end

    // State register plus the recording datapath it steers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            botoes_r  <= '0;
            jogada    <= '0;
            count     <= '0;
            wr_addr   <= '0;
            timeout   <= 1'b0;
            zera_idle <= 1'b1;
        end else begin
            estado    <= estado_prox;
            botoes_r  <= botoes;
            // Idle counter is held at zero in every state except ESPERA.
            zera_idle <= (estado_prox != ESPERA);
            case (estado)
                INICIAL, FIM, ERRO: begin
                    if (iniciar) begin
                        count   <= '0;
                        wr_addr <= '0;
                        timeout <= 1'b0;
                    end
                end
                ESPERA: begin
                    if (estado_prox == REGISTRA) jogada <= botoes_r;
                    if (por_timeout) timeout <= 1'b1;
                end
                REGISTRA: begin
                    count   <= count_mais_um;
                    wr_addr <= wr_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    contador_m #(
        .M(TIMEOUT)
    ) u_idle (
        .clock   (clock),
        .zera_as (zera_idle),
        .conta   (conta_idle),
        .fim     (idle_fim)
    );

    ram_16x7 #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (N_BOTOES)
    ) u_ram (
        .clock       (clock),
        .reset       (reset),
        .we          (escreve),
        .wr_endereco (wr_addr),
        .wr_dado     (jogada),
        .rd_endereco (rd_endereco),
        .rd_dado     (rd_dado)
    );

    assign gravando  = (estado == ESPERA) || (estado == SOLTA);
    assign pronto    = (estado == FIM);
    assign erro      = (estado == ERRO);
    assign db_estado = estado;
    // count==DEPTH wraps the low bits to zero, so the minus one still yields DEPTH-1.
    assign tamanho   = tem_jogadas ? (count[ADDR_W-1:0] - ADDR_W'(1)) : '0;

endmodule

// File: tb/tb_genius_gravador.sv
// tb/tb_genius_gravador.sv - directed self-checking bench for genius_gravador
module tb_genius_gravador;

    localparam int T = 5000;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       finalizar;
    logic [6:0] botoes;
    logic [3:0] rd_endereco;
    logic [6:0] rd_dado;
    logic       gravando;
    logic       pronto;
    logic       erro;
    logic       timeout;
    logic [3:0] tamanho;
    logic [2:0] db_estado;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    genius_gravador dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .finalizar   (finalizar),
        .botoes      (botoes),
        .rd_endereco (rd_endereco),
        .rd_dado     (rd_dado),
        .gravando    (gravando),
        .pronto      (pronto),
        .erro        (erro),
        .timeout     (timeout),
        .tamanho     (tamanho),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [6:0] v);
        botoes = v;
        step(3);
        botoes = '0;
        step(2);
    endtask

    task automatic start();
        iniciar = 1'b1;
        step(1);
        iniciar = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        iniciar     = 1'b0;
        finalizar   = 1'b0;
        botoes      = '0;
        rd_endereco = '0;
        step(2);
        check("rst_rd_dado", rd_dado, 0);
        check("rst_flags", {gravando, pronto, erro, timeout}, 0);
        check("rst_tamanho", tamanho, 0);
        check("rst_estado", db_estado, 0);
        reset = 1'b1;
        step(1);
        check("idle_estado", db_estado, 0);

        // Three presses then finalizar
        start();
        check("start_estado", db_estado, 1);
        check("start_gravando", gravando, 1);
        botoes = 7'h01;
        step(1);
        check("lat_k_espera", db_estado, 1);
        step(1);
        check("lat_k1_registra", db_estado, 2);
        step(1);
        check("lat_k2_solta", db_estado, 3);
        botoes = '0;
        step(2);
        check("release_espera", db_estado, 1);
        press(7'h04);
        press(7'h40);
        check("three_tamanho", tamanho, 2);
        finalizar = 1'b1;
        step(1);
        finalizar = 1'b0;
        check("fin_estado", db_estado, 4);
        check("fin_pronto", pronto, 1);
        check("fin_gravando", gravando, 0);
        check("fin_tamanho", tamanho, 2);
        rd_endereco = 4'd0;
        step(1);
        check("rd_addr0", rd_dado, 7'h01);
        rd_endereco = 4'd1;
        step(1);
        check("rd_addr1", rd_dado, 7'h04);
        rd_endereco = 4'd2;
        step(1);
        check("rd_addr2", rd_dado, 7'h40);

        // Sixteen presses fill the RAM and finish from REGISTRA
        start();
        check("restart_tamanho", tamanho, 0);
        for (int i = 0; i < 15; i++) begin
            press(7'(1 << (i % 7)));
        end
        check("fifteen_tamanho", tamanho, 14);
        botoes = 7'h02;
        step(2);
        check("last_registra", db_estado, 2);
        step(1);
        check("full_fim", db_estado, 4);
        botoes = '0;
        step(2);
        check("full_tamanho", tamanho, 15);
        check("full_pronto", pronto, 1);
        rd_endereco = 4'd15;
        step(1);
        check("rd_addr15", rd_dado, 7'h02);
        rd_endereco = 4'd7;
        step(1);
        check("rd_addr7", rd_dado, 7'h01);

        // Two buttons at once aborts
        start();
        botoes = 7'h03;
        step(2);
        check("bad_estado", db_estado, 5);
        check("bad_erro", erro, 1);
        check("bad_pronto", pronto, 0);
        botoes = '0;
        start();
        check("bad_restart", db_estado, 1);

        // finalizar with nothing recorded is ignored; empty timeout goes to ERRO
        finalizar = 1'b1;
        step(1);
        finalizar = 1'b0;
        check("fin_empty_ignored", db_estado, 1);
        step(T - 2);
        check("to_empty_before", db_estado, 1);
        check("to_empty_flag_before", timeout, 0);
        step(1);
        check("to_empty_estado", db_estado, 5);
        check("to_empty_flag", timeout, 1);

        // One press then timeout finishes with one play
        start();
        check("to_cleared", timeout, 0);
        press(7'h08);
        step(T - 1);
        check("to_one_before", db_estado, 1);
        step(1);
        check("to_one_estado", db_estado, 4);
        check("to_one_tamanho", tamanho, 0);
        check("to_one_flag", timeout, 1);

        // Long hold yields one write; finalizar during the hold
        start();
        botoes = 7'h10;
        step(50);
        check("hold_solta", db_estado, 3);
        check("hold_tamanho", tamanho, 0);
        finalizar = 1'b1;
        step(1);
        finalizar = 1'b0;
        check("hold_fim", db_estado, 4);
        check("hold_fim_tamanho", tamanho, 0);
        botoes = '0;
        rd_endereco = 4'd0;
        step(1);
        check("hold_rd0", rd_dado, 7'h10);

        // Reset in REGISTRA acts asynchronously and keeps RAM contents
        start();
        botoes = 7'h20;
        step(2);
        check("pre_rst_registra", db_estado, 2);
        #2;
        reset = 1'b0;
        #1;
        check("async_estado", db_estado, 0);
        check("async_flags", {gravando, pronto, erro, timeout}, 0);
        check("async_rd_dado", rd_dado, 0);
        check("async_tamanho", tamanho, 0);
        botoes = '0;
        step(1);
        reset = 1'b1;
        step(1);
        start();
        rd_endereco = 4'd0;
        step(1);
        check("post_rst_rd0", rd_dado, 7'h10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
